fp_add_arbiter: RTL and testbench
=================================

// Module: fp_add_arbiter
// PURPOSE
//  Shares one single-precision FP adder among NUM_REQ requesters. Round-robin accepts
//  one operand pair, issues it to the adder, waits for the result (watchdog-protected),
//  then returns it to the winning requester via a valid/ready response. Sits between
//  client engines and the adder instance; one operation in flight at a time.
// PARAMETERS
//  NUM_REQ   4   number of requesters (2..16)
//  TIMEOUT   8   cycles to wait in WAIT for add_res_vld before forcing an error result (>=2)
// PORTS
//  clk          in   1          rising-edge clock
//  rst          in   1          synchronous, active-high reset
//  req_vld      in   NUM_REQ    per-requester operand valid
//  req_a        in   32*NUM_REQ operand A, requester i at [32*i+:32]
//  req_b        in   32*NUM_REQ operand B, same packing
//  req_rdy      out  NUM_REQ    one-hot accept pulse
//  add_a        out  32         operand A to adder (held stable ISSUE..WAIT)
//  add_b        out  32         operand B to adder
//  add_vld      out  1          one-cycle issue strobe to adder i_vld
//  add_res      in   32         adder result
//  add_res_vld  in   1          adder result valid
//  add_ovf      in   1          adder overflow/special flag
//  rsp_vld      out  NUM_REQ    one-hot response valid, held until accepted
//  rsp_res      out  32         result to granted requester
//  rsp_ovf      out  1          overflow flag captured with result
//  rsp_err      out  1          1 = watchdog expired, rsp_res = 32'h7FC00000
//  rsp_rdy      in   NUM_REQ    per-requester response accept
//  busy         out  1          high in any state other than IDLE
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, rr_ptr=0, gnt=0, wdog=0; all outputs 0 next cycle.
//   Reset mid-operation drops the in-flight op; no response issued; late add_res_vld ignored.
//  FSM states IDLE, ISSUE, WAIT, RESP:
//   IDLE : if |req_vld, winner = first set req_vld[k] scanning k=rr_ptr,rr_ptr+1,..
//          mod NUM_REQ; req_rdy[winner]=1 (combinational, this cycle only); latch
//          req_a/req_b[winner] into add_a/add_b, gnt=winner; -> ISSUE. Else stay.
//   ISSUE: add_vld=1 for exactly one cycle; wdog cleared; -> WAIT.
//   WAIT : add_res_vld=1 -> latch rsp_res=add_res, rsp_ovf=add_ovf, rsp_err=0; -> RESP.
//          else if wdog==TIMEOUT-1 -> rsp_res=32'h7FC00000, rsp_ovf=0, rsp_err=1; -> RESP.
//          else wdog++. add_res_vld and timeout in same cycle: result wins.
//   RESP : rsp_vld[gnt]=1, rsp_res/ovf/err stable; on rsp_rdy[gnt]: rr_ptr=(gnt+1)
//          mod NUM_REQ (wrap), -> IDLE. rsp_rdy on other bits ignored.
//  add_res_vld outside WAIT ignored. req_vld may drop before accept (no loss: not taken).
//  Latency: accept->issue 1 cycle; adder 1 cycle; min accept->rsp_vld = 3 cycles;
//   max issue rate one op per 4 cycles with rsp_rdy held high.
//  Fairness: requester held valid served within NUM_REQ grants.
//  wdog width $clog2(TIMEOUT); gnt/rr_ptr width $clog2(NUM_REQ) (min 1).
// STRUCTURE
//  Shared package fpu_pkg: FP32_QNAN=32'h7FC00000, arb FSM state encoding
//   (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3).
//  Sub-module rr_pick: combinational round-robin chooser (req vector, ptr ->
//   one-hot grant + index + any). Rest (FSM, latches, watchdog) in this module.
// TESTING
//  1 Single req0: a=3F800000,b=40000000 -> add_vld 1 cycle after accept; rsp_vld[0]
//    with rsp_res=40400000, rsp_err=0 3 cycles after accept; rr_ptr=1.
//  2 All 4 req_vld held, rsp_rdy=1111 -> grant order 0,1,2,3,0; each op 4 cycles.
//  3 Adder stub never returns, TIMEOUT=8 -> rsp_res=7FC00000, rsp_err=1 after
//    8 WAIT cycles; subsequent request handled normally.
//  4 rsp_rdy[gnt]=0 for 5 cycles -> rsp_vld and rsp_res stable, no new accept
//    (req_rdy=0) until rsp_rdy asserted.
//  5 rst asserted in WAIT, adder returns next cycle -> no rsp_vld, busy=0, rr_ptr=0.
//  6 add_res_vld coincident with wdog==TIMEOUT-1 -> adder result returned, rsp_err=0;
//    add_ovf=1 with res=7F800000 -> rsp_ovf=1.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FP-unit definitions: canonical quiet NaN, arbiter state encoding, index-width helper.
package fpu_pkg;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fp_add_arbiter_rr_pick.sv
// Combinational round-robin chooser: first set request at or after ptr, wrapping.
module rr_pick
  import fpu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned PW     = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [PW-1:0]      gnt_idx,
  output logic               any
);

  always_comb begin
    int unsigned k;
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    k       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = (32'(ptr) + i) % NUM_REQ;
      if (!any && req[k]) begin
        any       = 1'b1;
        gnt_oh[k] = 1'b1;
        gnt_idx   = PW'(k);
      end
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one FP32 adder among NUM_REQ requesters, one op in flight, watchdog on the adder result.
module fp_add_arbiter
  import fpu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_vld,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_rdy,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  output logic                  add_vld,
  input  logic [31:0]           add_res,
  input  logic                  add_res_vld,
  input  logic                  add_ovf,
  output logic [NUM_REQ-1:0]    rsp_vld,
  output logic [31:0]           rsp_res,
  output logic                  rsp_ovf,
  output logic                  rsp_err,
  input  logic [NUM_REQ-1:0]    rsp_rdy,
  output logic                  busy
);

  localparam int unsigned PW = idx_w(NUM_REQ);
  localparam int unsigned WW = $clog2(TIMEOUT);

  arb_state_t           state, state_nxt;
  logic [PW-1:0]        gnt, rr_ptr, pick_idx;
  logic [NUM_REQ-1:0]   pick_oh;
  logic                 pick_any;
  logic [WW-1:0]        wdog;
  logic                 accept, res_take, wd_expire, rsp_done;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (req_vld),
    .ptr     (rr_ptr),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    res_take  = 1'b0;
    wd_expire = 1'b0;
    rsp_done  = 1'b0;
    req_rdy   = '0;
    rsp_vld   = '0;
    add_vld   = 1'b0;
    busy      = (state != ARB_IDLE);
    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          accept    = 1'b1;
          req_rdy   = pick_oh;
          state_nxt = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        add_vld   = 1'b1;
        state_nxt = ARB_WAIT;
      end
      ARB_WAIT: begin
        // a result arriving on the last watchdog cycle takes priority over the timeout
        if (add_res_vld) begin
          res_take  = 1'b1;
          state_nxt = ARB_RESP;
        end else if (wdog == WW'(TIMEOUT - 1)) begin
          wd_expire = 1'b1;
          state_nxt = ARB_RESP;
        end
      end
      ARB_RESP: begin
        rsp_vld[gnt] = 1'b1;
        if (rsp_rdy[gnt]) begin
          rsp_done  = 1'b1;
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      add_a   <= '0;
      add_b   <= '0;
      gnt     <= '0;
      rr_ptr  <= '0;
      wdog    <= '0;
      rsp_res <= '0;
      rsp_ovf <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      if (accept) begin
        add_a <= req_a[{pick_idx, 5'b0} +: 32];
        add_b <= req_b[{pick_idx, 5'b0} +: 32];
        gnt   <= pick_idx;
      end
      if (state == ARB_ISSUE)
        wdog <= '0;
      else if (state == ARB_WAIT && !res_take && !wd_expire)
        wdog <= wdog + 1'b1;
      if (res_take) begin
        rsp_res <= add_res;
        rsp_ovf <= add_ovf;
        rsp_err <= 1'b0;
      end
      if (wd_expire) begin
        rsp_res <= FP32_QNAN;
        rsp_ovf <= 1'b0;
        rsp_err <= 1'b1;
      end
      if (rsp_done)
        rr_ptr <= (32'(gnt) == NUM_REQ - 1) ? '0 : gnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: directed vector table, reset-in-flight sequence, randomized traffic.
module tb_fp_add_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_vld, req_rdy, rsp_vld, rsp_rdy;
  logic [32*N-1:0] req_a, req_b;
  logic [31:0]     add_a, add_b, add_res, rsp_res;
  logic            add_vld, add_res_vld, add_ovf, rsp_ovf, rsp_err, busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_add_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_a(req_a), .req_b(req_b), .req_rdy(req_rdy),
    .add_a(add_a), .add_b(add_b), .add_vld(add_vld),
    .add_res(add_res), .add_res_vld(add_res_vld), .add_ovf(add_ovf),
    .rsp_vld(rsp_vld), .rsp_res(rsp_res), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
    .rsp_rdy(rsp_rdy), .busy(busy)
  );

  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'd0) return 0.0;
    d = {x[31], 11'(32'(x[30:23]) + 896), x[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    return {d[63], 8'(32'(d[62:52]) - 896), d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
  endfunction

  // adder stub: answers stub_d cycles after the issue strobe (0 = never answers)
  int          stub_d   = 1;
  logic        stub_frc = 1'b0;
  int          scnt;
  bit          spend;
  logic [31:0] sa, sb;
  initial begin
    add_res_vld = 1'b0; add_res = '0; add_ovf = 1'b0; spend = 1'b0; scnt = 0;
    forever begin
      @(negedge clk);
      add_res_vld = 1'b0;
      if (spend) begin
        scnt--;
        if (scnt == 0) begin
          spend       = 1'b0;
          add_res_vld = 1'b1;
          add_res     = stub_frc ? 32'h7F80_0000 : fadd(sa, sb);
          add_ovf     = stub_frc;
        end
      end
      if (add_vld && stub_d > 0) begin
        spend = 1'b1; scnt = stub_d; sa = add_a; sb = add_b;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // entered at the drive point of an idle cycle with requests applied; leaves at the next idle drive point
  task automatic serve(input int w, input int d, input int stall,
                       input logic [31:0] er, input logic eo, input logic ee);
    int nw;
    logic [31:0] ea, eb;
    logic [N-1:0] oh;
    oh = N'(1) << w;
    ea = req_a[32*w +: 32];
    eb = req_b[32*w +: 32];
    stub_d = d;
    nw = (d >= 1 && d <= TO) ? d : TO;
    @(negedge clk);
    chk("accept_rdy", req_rdy, oh);
    chk("idle_busy", busy, 0);
    @(posedge clk); #1;
    req_vld[w] = 1'b0;
    @(negedge clk);
    chk("issue_vld", add_vld, 1);
    chk("issue_a", add_a, ea);
    chk("issue_b", add_b, eb);
    chk("issue_rdy", req_rdy, 0);
    for (int j = 0; j < nw; j++) begin
      @(negedge clk);
      chk("wait_add_vld", add_vld, 0);
      chk("wait_rsp_vld", rsp_vld, 0);
      chk("wait_add_a", add_a, ea);
      chk("wait_busy", busy, 1);
    end
    for (int k = 0; k <= stall; k++) begin
      @(posedge clk); #1;
      rsp_rdy = N'($urandom);
      rsp_rdy[w] = (k == stall);
      @(negedge clk);
      chk("rsp_vld", rsp_vld, oh);
      chk("rsp_res", rsp_res, er);
      chk("rsp_ovf", rsp_ovf, eo);
      chk("rsp_err", rsp_err, ee);
      chk("rsp_req_rdy", req_rdy, 0);
    end
    @(posedge clk); #1;
    rsp_rdy = '0;
  endtask

  typedef struct {
    logic [N-1:0] vld;
    int           w;
    logic [31:0]  a, b;
    int           d;
    int           stall;
    logic         frc;
    logic [31:0]  res;
    logic         ovf;
    logic         err;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [31:0] er;
    logic        ee;
    int          mptr, w, d;
    bit          pend [N];
    logic [31:0] pa [N], pb [N];
    int          dl [5];

    tbl[0] = '{4'b0001, 0, 32'h3F80_0000, 32'h4000_0000, 1,  0, 1'b0, 32'h4040_0000, 1'b0, 1'b0};
    tbl[1] = '{4'b0011, 1, 32'h4000_0000, 32'h4000_0000, 1,  0, 1'b0, 32'h4080_0000, 1'b0, 1'b0};
    tbl[2] = '{4'b1111, 2, 32'h3FC0_0000, 32'h3F00_0000, 1,  0, 1'b0, 32'h4000_0000, 1'b0, 1'b0};
    tbl[3] = '{4'b1111, 3, 32'h3F00_0000, 32'h3E80_0000, 1,  0, 1'b0, 32'h3F40_0000, 1'b0, 1'b0};
    tbl[4] = '{4'b1111, 0, 32'hBF80_0000, 32'h4040_0000, 1,  0, 1'b0, 32'h4000_0000, 1'b0, 1'b0};
    tbl[5] = '{4'b0001, 0, 32'h3F80_0000, 32'h3F80_0000, 0,  0, 1'b0, QNAN,          1'b0, 1'b1};
    tbl[6] = '{4'b0010, 1, 32'h4040_0000, 32'h4040_0000, 1,  5, 1'b0, 32'h40C0_0000, 1'b0, 1'b0};
    tbl[7] = '{4'b0101, 2, 32'h4000_0000, 32'h3F80_0000, TO, 0, 1'b1, 32'h7F80_0000, 1'b1, 1'b0};
    tbl[8] = '{4'b0001, 0, 32'h4080_0000, 32'h3F80_0000, 2,  1, 1'b0, 32'h40A0_0000, 1'b0, 1'b0};
    dl = '{1, 2, 3, TO, 0};

    rst = 1'b1; req_vld = '0; rsp_rdy = '0; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_add_vld", add_vld, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_rsp_vld", rsp_vld, 0);
    chk("rst_rsp_res", rsp_res, 0);
    chk("rst_rsp_flags", {rsp_ovf, rsp_err}, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      for (int j = 0; j < N; j++) begin
        req_a[32*j +: 32] = 32'hA000_0000 | j;
        req_b[32*j +: 32] = 32'hB000_0000 | j;
      end
      req_a[32*tbl[i].w +: 32] = tbl[i].a;
      req_b[32*tbl[i].w +: 32] = tbl[i].b;
      req_vld  = tbl[i].vld;
      stub_frc = tbl[i].frc;
      serve(tbl[i].w, tbl[i].d, tbl[i].stall, tbl[i].res, tbl[i].ovf, tbl[i].err);
      stub_frc = 1'b0;
      req_vld  = '0;
    end

    // reset while waiting on the adder; the late result must be dropped and the pointer cleared
    req_a[32*2 +: 32] = 32'h3F80_0000;
    req_b[32*2 +: 32] = 32'h3F80_0000;
    req_vld = 4'b0100;
    stub_d  = 3;
    @(negedge clk);
    chk("r5_accept", req_rdy, 4'b0100);
    @(posedge clk); #1;
    req_vld = '0;
    @(negedge clk);
    chk("r5_issue", add_vld, 1);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("r5_rsp_vld", rsp_vld, 0);
      chk("r5_busy", busy, 0);
      chk("r5_add_vld", add_vld, 0);
    end
    @(posedge clk); #1;
    req_a[32*0 +: 32] = 32'h4000_0000; req_b[32*0 +: 32] = 32'h4000_0000;
    req_a[32*3 +: 32] = 32'h3F80_0000; req_b[32*3 +: 32] = 32'h3F80_0000;
    req_vld = 4'b1001;
    serve(0, 1, 0, 32'h4080_0000, 1'b0, 1'b0);
    mptr = 1;
    pend[3] = 1'b1; pa[3] = 32'h3F80_0000; pb[3] = 32'h3F80_0000;
    for (int j = 0; j < 3; j++) pend[j] = 1'b0;

    for (int op = 0; op < 40; op++) begin
      for (int j = 0; j < N; j++)
        if (!pend[j] && $urandom_range(0, 1) == 1) begin
          pend[j] = 1'b1; pa[j] = rnd_fp(); pb[j] = rnd_fp();
        end
      if (!(pend[0] || pend[1] || pend[2] || pend[3])) begin
        w = $urandom_range(0, N - 1);
        pend[w] = 1'b1; pa[w] = rnd_fp(); pb[w] = rnd_fp();
      end
      for (int j = 0; j < N; j++) begin
        req_vld[j] = pend[j];
        req_a[32*j +: 32] = pa[j];
        req_b[32*j +: 32] = pb[j];
      end
      w = -1;
      for (int k = N - 1; k >= 0; k--)
        if (pend[(mptr + k) % N]) w = (mptr + k) % N;
      d = dl[$urandom_range(0, 4)];
      if (d >= 1 && d <= TO) begin er = fadd(pa[w], pb[w]); ee = 1'b0; end
      else begin er = QNAN; ee = 1'b1; end
      serve(w, d, $urandom_range(0, 3), er, 1'b0, ee);
      pend[w] = 1'b0;
      mptr = (w + 1) % N;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

endmodule
